// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART bit-timing blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Rounded {int, frac} divisor for CLK_FREQ / (BAUD * OVERSAMPLE).
    function automatic longint unsigned calc_div(
        input longint unsigned clk_freq,
        input longint unsigned baud,
        input longint unsigned os,
        input longint unsigned frac_w
    );
        longint unsigned num;
        longint unsigned den;
        num = clk_freq << frac_w;
        den = baud * os;
        return (2 * num + den) / (2 * den);
    endfunction

    // Counter width for a modulus, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Fractional clock divider: holds the divisor and emits one tick_os per
// int + frac/2^FRAC_W cycles on average.
module uart_frac_div #(
    parameter int unsigned               DIV_W     = 16,
    parameter int unsigned               FRAC_W    = 8,
    parameter logic [DIV_W+FRAC_W-1:0]   DIV_RESET = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      active,
    input  logic                      clr,
    input  logic                      load,
    input  logic [DIV_W+FRAC_W-1:0]   load_val,
    output logic                      tick_os
);
    localparam int unsigned TOT_W = DIV_W + FRAC_W;

    logic [TOT_W-1:0]  div_q;
    logic [DIV_W-1:0]  os_cnt;
    logic [FRAC_W-1:0] frac_acc;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic [DIV_W-1:0]  load_int;
    logic [FRAC_W-1:0] frac_sum;
    logic              carry;
    logic [DIV_W:0]    last_cnt;

    // Period length is int plus the carry out of the fractional accumulator.
    always_comb begin
        div_int           = div_q[TOT_W-1:FRAC_W];
        div_frac          = div_q[FRAC_W-1:0];
        {carry, frac_sum} = {1'b0, frac_acc} + {1'b0, div_frac};
        last_cnt          = {1'b0, div_int} + (DIV_W+1)'(carry) - (DIV_W+1)'(1);
        tick_os           = active && ({1'b0, os_cnt} == last_cnt);
        load_int          = (load_val[TOT_W-1:FRAC_W] == '0) ? DIV_W'(1)
                                                              : load_val[TOT_W-1:FRAC_W];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q    <= DIV_RESET;
            os_cnt   <= '0;
            frac_acc <= '0;
        end else begin
            if (load) begin
                div_q <= {load_int, load_val[FRAC_W-1:0]};
            end
            if (clr) begin
                os_cnt   <= '0;
                frac_acc <= '0;
            end else if (active) begin
                os_cnt <= tick_os ? '0 : os_cnt + DIV_W'(1);
                if (load) begin
                    frac_acc <= '0;
                end else if (tick_os) begin
                    frac_acc <= frac_sum;
                end
            end
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// UART bit timer shared by TX and RX: oversample, mid-bit and end-of-bit
// ticks plus frame bit index, with a runtime fractional divisor.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 8,
    parameter int unsigned FRAME_BITS = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                oneshot,
    input  logic                                div_wr,
    input  logic [DIV_W+FRAC_W-1:0]             div_in,
    output logic                                div_busy,
    output logic                                tick_os,
    output logic                                bit_mid,
    output logic                                bit_end,
    output logic [cnt_w(FRAME_BITS)-1:0]        bit_idx,
    output logic                                frame_done,
    output logic                                running
);
    localparam int unsigned TOT_W = DIV_W + FRAC_W;
    localparam int unsigned OS_W  = cnt_w(OVERSAMPLE);
    localparam int unsigned IDX_W = cnt_w(FRAME_BITS);
    localparam logic [TOT_W-1:0] DIV_RESET =
        TOT_W'(calc_div(64'(CLK_FREQ), 64'(BAUD), 64'(OVERSAMPLE), 64'(FRAC_W)));

    state_t            state_q;
    state_t            state_d;
    logic [OS_W-1:0]   sub_cnt;
    logic [TOT_W-1:0]  pend_q;
    logic              clr_c;
    logic              load_c;
    logic [TOT_W-1:0]  load_val_c;
    logic              pend_set_c;
    logic              pend_clr_c;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
                     else if (frame_done && oneshot) state_d = DONE;
            DONE:    if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        clr_c = (state_d != RUN);
    end

    always_comb begin
        running    = (state_q == RUN);
        bit_mid    = tick_os && (sub_cnt == OS_W'(OVERSAMPLE/2 - 1));
        bit_end    = tick_os && (sub_cnt == OS_W'(OVERSAMPLE - 1));
        frame_done = bit_end && (bit_idx == IDX_W'(FRAME_BITS - 1));
    end

    // Outside RUN writes go straight in; inside RUN they wait for a bit boundary.
    always_comb begin
        load_c     = 1'b0;
        load_val_c = div_in;
        pend_set_c = 1'b0;
        pend_clr_c = 1'b0;
        if (state_q != RUN || !en) begin
            if (div_wr) begin
                load_c = 1'b1;
            end else if (div_busy) begin
                load_c     = 1'b1;
                load_val_c = pend_q;
            end
            pend_clr_c = div_busy;
        end else begin
            if (bit_end && div_busy) begin
                load_c     = 1'b1;
                load_val_c = pend_q;
                pend_clr_c = 1'b1;
            end
            pend_set_c = div_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q   <= '0;
            div_busy <= 1'b0;
        end else if (pend_set_c) begin
            pend_q   <= div_in;
            div_busy <= 1'b1;
        end else if (pend_clr_c) begin
            div_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sub_cnt <= '0;
            bit_idx <= '0;
        end else if (clr_c) begin
            sub_cnt <= '0;
            bit_idx <= '0;
        end else if (tick_os) begin
            sub_cnt <= bit_end ? '0 : sub_cnt + OS_W'(1);
            if (bit_end) begin
                bit_idx <= frame_done ? '0 : bit_idx + IDX_W'(1);
            end
        end
    end

    uart_frac_div #(
        .DIV_W     (DIV_W),
        .FRAC_W    (FRAC_W),
        .DIV_RESET (DIV_RESET)
    ) u_frac_div (
        .clk      (clk),
        .rst      (rst),
        .active   (running),
        .clr      (clr_c),
        .load     (load_c),
        .load_val (load_val_c),
        .tick_os  (tick_os)
    );

endmodule
